cd_csr_gen2: RTL and testbench
==============================

Name: cd_csr_gen2

Overview:
Second-generation CDBUS control/status register block on the Avalon-MM slave port. It adds the following over the current CSR set:
- N_FILTER parametrised multicast filters.
- Write-1-to-clear sticky interrupt flags and a registered irq.
- Registered read data with 1-cycle latency and a readdatavalid strobe.
- Saturating statistics counters with an atomic snapshot.
It sits between the host bus and the cdbus rx/tx datapaths and drives all their configuration and command strobes.

Parameters:
- VERSION, 8'h10, value returned by the version register.
- DIV_LS, 346, reset value of div_ls (115200 bps at 40 MHz).
- DIV_HS, 346, reset value of div_hs.
- N_FILTER, 2, number of multicast filters, legal range 1..8.
- CNT_W, 16, statistics counter width, legal range 8..32.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- irq  out  1  registered interrupt, (int_flag & int_mask) != 0
- csr_address  in  5  word address
- csr_byteenable  in  4  byte enables
- csr_read  in  1  read request
- csr_readdata  out  32  registered read data
- csr_readdatavalid  out  1  high one cycle after an accepted csr_read
- csr_write  in  1  write request
- csr_writedata  in  32  write data
- full_duplex, break_sync, arbitration, not_drop, user_crc, tx_invert, tx_push_pull  out  1 each  mode bits
- idle_wait_len  out  8  idle wait length
- tx_permit_len  out  10  tx permit length
- max_idle_len  out  10  max idle length
- tx_pre_len  out  2  tx preamble length
- filter  out  8  unicast filter
- filter_m  out  8*N_FILTER  multicast filters, filter k at bits [8k+7:8k]
- div_ls  out  16  low-speed divider
- div_hs  out  16  high-speed divider
- rx_ram_rd_done, rx_clean_all  out  1  one-cycle rx command strobes
- rx_ram_rd_flags  in  8  rx page flags
- rx_error, rx_ram_lost, rx_break, rx_frame_done  in  1  one-cycle event pulses
- rx_pending, bus_idle  in  1  levels
- tx_ram_switch, tx_abort  out  1  one-cycle tx command strobes
- has_break  out  1  break request level
- ack_break, cd, tx_err  in  1  event pulses
- tx_pending  in  1  level

Behaviour:

Register map:
- 0x00 VERSION: read-only.
- 0x01 SETTING: bits [6:0] = full_duplex .. tx_push_pull.
- 0x02 IDLE_WAIT_LEN.
- 0x03 TX_PERMIT_LEN.
- 0x04 MAX_IDLE_LEN.
- 0x05 TX_PRE_LEN.
- 0x06 FILTER.
- 0x07 DIV_LS.
- 0x08 DIV_HS.
- 0x09 INT_FLAG: read, or write-1-to-clear.
- 0x0a INT_MASK.
- 0x0b RX_CTRL: bit4 = clean_all, bit1 = rd_done.
- 0x0c TX_CTRL: bit5 = break, bit4 = abort, bit1 = switch.
- 0x0d RX_PAGE_FLAG.
- 0x0e FILTER_M0: filters 0..3, one byte lane each.
- 0x0f FILTER_M1: filters 4..7.
- 0x10 CNT_RX_FRAME.
- 0x11 CNT_RX_ERR: counts rx_error and rx_ram_lost.
- 0x12 CNT_CD.
- 0x13 CNT_TX_ERR.
- 0x14 CNT_CTRL: bit0 = clear, bit1 = snapshot.
- Unmapped and unimplemented addresses (e.g. filter bytes >= N_FILTER) read 0 and ignore writes.

Reset values:
- arbitration = 1; all other mode bits 0.
- idle_wait_len 10, tx_permit_len 20, max_idle_len 200, tx_pre_len 1.
- filter and all filter_m bytes 8'hff.
- div_ls = DIV_LS, div_hs = DIV_HS.
- int_mask 0, all sticky flags 0, counters and shadows 0.
- All strobes 0; has_break 0, irq 0, csr_readdatavalid 0, csr_readdata 0.

Writes:
- Take effect on the cycle after csr_write.
- Byte lanes are gated per csr_byteenable, exactly as for multi-byte fields.

Reads:
- csr_readdata is sampled from the addressed register at the csr_read edge.
- csr_readdatavalid is high the next cycle only.
- Back-to-back reads give one valid per cycle.

INT_FLAG:
- Layout is {tx_err_f, cd_f, ~tx_pending, rx_err_f, rx_lost_f, rx_break_f, rx_pending, bus_idle}.
- Bits 7, 6, 4, 3 and 2 are sticky.
- Writing 1 clears a sticky bit; reads have no side effect.
- If an event pulse coincides with a clear write, the set wins.

irq: registered from int_flag & int_mask, so it lags the flag or mask change by 1 cycle.

Strobes:
- Each command strobe is high for exactly 1 cycle per qualifying write.

has_break:
- Set by a TX_CTRL bit5 write; cleared by ack_break.
- If both occur in the same cycle, the set wins.

Counters:
- Each counter increments by 1 per event cycle and saturates at 2^CNT_W - 1 (no wrap).
- CNT_RX_ERR increments by 1 even if rx_error and rx_ram_lost coincide.

Snapshot:
- Writing CNT_CTRL bit1 copies all live counters into shadows in one cycle.
- Counter addresses always read the shadows, zero-extended to 32 bits.

Clear:
- Writing CNT_CTRL bit0 zeroes the live counters.
- If an event coincides with a clear, the live counter becomes 0; the event is dropped.
- If clear and snapshot are written together, the shadow takes the pre-clear value.

Reset mid-operation: asynchronous; all state returns to reset values immediately and any pending readdatavalid is dropped.

Decomposition:
- Package cd_csr_pkg: register address constants, INT_FLAG bit indices, and the reset value constants above.
- Sub-module cd_sat_cnt: a CNT_W saturating counter with inc, clr and snap inputs and live and shadow outputs. It is instantiated four times.

Test Plan:
1. Reset, then read each register -> VERSION 0x10, SETTING 0x10, IDLE 10, PERMIT 20, MAXIDLE 200, FILTER_M0 0x0000ffff at N_FILTER=2; readdatavalid high exactly 1 cycle after each read.
2. Write TX_PERMIT_LEN 0x3ff with byteenable 4'b0010 -> value reads 0x314; then byteenable 4'b0001 with data 0x0ab -> value reads 0x3ab.
3. Pulse rx_error, set INT_MASK bit4, write INT_FLAG 0x10 in the same cycle as a second rx_error -> flag stays 1 and irq stays 1; a later clear write -> flag 0 and irq 0 one cycle later.
4. With CNT_W=8, apply 300 rx_frame_done pulses, then snapshot -> CNT_RX_FRAME reads 255; clear+snapshot in the same write -> reads 255, next snapshot reads 0.
5. Write TX_CTRL 0x20 in the same cycle as ack_break -> has_break 1; a subsequent ack_break alone -> has_break 0; TX_CTRL 0x12 -> tx_abort and tx_ram_switch each high exactly 1 cycle.
6. Deassert reset_n while a read is in flight and counters are nonzero -> readdatavalid 0, all counters 0, filters 0xff.

Source files
------------

// File: rtl/cd_csr_pkg.sv
// cd_csr_pkg: register map, INT_FLAG bit positions and reset values for cd_csr_gen2.
package cd_csr_pkg;
  localparam logic [4:0] A_VERSION       = 5'h00;
  localparam logic [4:0] A_SETTING       = 5'h01;
  localparam logic [4:0] A_IDLE_WAIT_LEN = 5'h02;
  localparam logic [4:0] A_TX_PERMIT_LEN = 5'h03;
  localparam logic [4:0] A_MAX_IDLE_LEN  = 5'h04;
  localparam logic [4:0] A_TX_PRE_LEN    = 5'h05;
  localparam logic [4:0] A_FILTER        = 5'h06;
  localparam logic [4:0] A_DIV_LS        = 5'h07;
  localparam logic [4:0] A_DIV_HS        = 5'h08;
  localparam logic [4:0] A_INT_FLAG      = 5'h09;
  localparam logic [4:0] A_INT_MASK      = 5'h0a;
  localparam logic [4:0] A_RX_CTRL       = 5'h0b;
  localparam logic [4:0] A_TX_CTRL       = 5'h0c;
  localparam logic [4:0] A_RX_PAGE_FLAG  = 5'h0d;
  localparam logic [4:0] A_FILTER_M0     = 5'h0e;
  localparam logic [4:0] A_FILTER_M1     = 5'h0f;
  localparam logic [4:0] A_CNT_RX_FRAME  = 5'h10;
  localparam logic [4:0] A_CNT_RX_ERR    = 5'h11;
  localparam logic [4:0] A_CNT_CD        = 5'h12;
  localparam logic [4:0] A_CNT_TX_ERR    = 5'h13;
  localparam logic [4:0] A_CNT_CTRL      = 5'h14;
  localparam int INT_TX_ERR     = 7;
  localparam int INT_CD         = 6;
  localparam int INT_TX_IDLE    = 5;
  localparam int INT_RX_ERR     = 4;
  localparam int INT_RX_LOST    = 3;
  localparam int INT_RX_BREAK   = 2;
  localparam int INT_RX_PENDING = 1;
  localparam int INT_BUS_IDLE   = 0;
  localparam logic [6:0] RST_SETTING   = 7'h10;
  localparam logic [7:0] RST_IDLE_WAIT = 8'd10;
  localparam logic [9:0] RST_TX_PERMIT = 10'd20;
  localparam logic [9:0] RST_MAX_IDLE  = 10'd200;
  localparam logic [1:0] RST_TX_PRE    = 2'd1;
  localparam logic [7:0] RST_FILTER    = 8'hff;
endpackage

// File: rtl/cd_sat_cnt.sv
// cd_sat_cnt: saturating event counter with synchronous clear and shadow snapshot.
// Ports: inc counts one event, clr zeroes live (dropping a coincident event),
// snap copies the pre-clear live value into shadow.
module cd_sat_cnt #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             inc,
  input  logic             clr,
  input  logic             snap,
  output logic [CNT_W-1:0] live,
  output logic [CNT_W-1:0] shadow
);
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      live   <= '0;
      shadow <= '0;
    end else begin
      if (snap) shadow <= live;
      live <= clr ? '0 : (inc && !(&live)) ? live + CNT_W'(1) : live;
    end
endmodule

// File: rtl/cd_csr_gen2.sv
// cd_csr_gen2: CDBUS control/status registers on an Avalon-MM slave.
// Ports: csr_* Avalon slave (1-cycle registered read), irq; mode/length/filter/divider
// configuration outputs; rx/tx command strobes and has_break; rx/tx status pulses and levels.
module cd_csr_gen2 import cd_csr_pkg::*; #(
  parameter logic [7:0]  VERSION  = 8'h10,
  parameter logic [15:0] DIV_LS   = 16'd346,
  parameter logic [15:0] DIV_HS   = 16'd346,
  parameter int          N_FILTER = 2,
  parameter int          CNT_W    = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  output logic                  irq,
  input  logic [4:0]            csr_address,
  input  logic [3:0]            csr_byteenable,
  input  logic                  csr_read,
  output logic [31:0]           csr_readdata,
  output logic                  csr_readdatavalid,
  input  logic                  csr_write,
  input  logic [31:0]           csr_writedata,
  output logic                  full_duplex,
  output logic                  break_sync,
  output logic                  arbitration,
  output logic                  not_drop,
  output logic                  user_crc,
  output logic                  tx_invert,
  output logic                  tx_push_pull,
  output logic [7:0]            idle_wait_len,
  output logic [9:0]            tx_permit_len,
  output logic [9:0]            max_idle_len,
  output logic [1:0]            tx_pre_len,
  output logic [7:0]            filter,
  output logic [8*N_FILTER-1:0] filter_m,
  output logic [15:0]           div_ls,
  output logic [15:0]           div_hs,
  output logic                  rx_ram_rd_done,
  output logic                  rx_clean_all,
  input  logic [7:0]            rx_ram_rd_flags,
  input  logic                  rx_error,
  input  logic                  rx_ram_lost,
  input  logic                  rx_break,
  input  logic                  rx_frame_done,
  input  logic                  rx_pending,
  input  logic                  bus_idle,
  output logic                  tx_ram_switch,
  output logic                  tx_abort,
  output logic                  has_break,
  input  logic                  ack_break,
  input  logic                  cd,
  input  logic                  tx_err,
  input  logic                  tx_pending
);
  // All eight filter bytes are held; bytes >= N_FILTER are masked from reads and outputs.
  localparam logic [63:0] FM_MASK = (64'd1 << (8 * N_FILTER)) - 64'd1;
  logic [6:0]       setting;
  logic [63:0]      fm;
  logic [7:0]       int_mask, sticky, int_flag, int_set, ctl;
  logic [31:0]      wm, rd_mux;
  logic [3:0]       cnt_inc;
  logic             cnt_clr, cnt_snap;
  logic [CNT_W-1:0] cnt_live [4];
  logic [CNT_W-1:0] cnt_shadow [4];
  function automatic logic we(input logic [4:0] a);
    return csr_write && csr_address == a;
  endfunction
  assign {full_duplex, break_sync, arbitration, not_drop, user_crc, tx_invert, tx_push_pull} = setting;
  assign filter_m = fm[8*N_FILTER-1:0];
  assign wm  = {{8{csr_byteenable[3]}}, {8{csr_byteenable[2]}}, {8{csr_byteenable[1]}}, {8{csr_byteenable[0]}}};
  assign ctl = csr_writedata[7:0] & wm[7:0];
  assign cnt_inc  = {tx_err, cd, rx_error | rx_ram_lost, rx_frame_done};
  assign cnt_clr  = we(A_CNT_CTRL) & ctl[0];
  assign cnt_snap = we(A_CNT_CTRL) & ctl[1];
  always_comb begin
    int_set = '0;
    int_set[INT_TX_ERR]   = tx_err;
    int_set[INT_CD]       = cd;
    int_set[INT_RX_ERR]   = rx_error;
    int_set[INT_RX_LOST]  = rx_ram_lost;
    int_set[INT_RX_BREAK] = rx_break;
    int_flag = sticky;
    int_flag[INT_TX_IDLE]    = ~tx_pending;
    int_flag[INT_RX_PENDING] = rx_pending;
    int_flag[INT_BUS_IDLE]   = bus_idle;
  end
  always_comb begin
    rd_mux = '0;
    case (csr_address)
      A_VERSION:       rd_mux = {24'b0, VERSION};
      A_SETTING:       rd_mux = {25'b0, setting};
      A_IDLE_WAIT_LEN: rd_mux = {24'b0, idle_wait_len};
      A_TX_PERMIT_LEN: rd_mux = {22'b0, tx_permit_len};
      A_MAX_IDLE_LEN:  rd_mux = {22'b0, max_idle_len};
      A_TX_PRE_LEN:    rd_mux = {30'b0, tx_pre_len};
      A_FILTER:        rd_mux = {24'b0, filter};
      A_DIV_LS:        rd_mux = {16'b0, div_ls};
      A_DIV_HS:        rd_mux = {16'b0, div_hs};
      A_INT_FLAG:      rd_mux = {24'b0, int_flag};
      A_INT_MASK:      rd_mux = {24'b0, int_mask};
      A_TX_CTRL:       rd_mux = {26'b0, has_break, 5'b0};
      A_RX_PAGE_FLAG:  rd_mux = {24'b0, rx_ram_rd_flags};
      A_FILTER_M0:     rd_mux = fm[31:0] & FM_MASK[31:0];
      A_FILTER_M1:     rd_mux = fm[63:32] & FM_MASK[63:32];
      A_CNT_RX_FRAME:  rd_mux = 32'(cnt_shadow[0]);
      A_CNT_RX_ERR:    rd_mux = 32'(cnt_shadow[1]);
      A_CNT_CD:        rd_mux = 32'(cnt_shadow[2]);
      A_CNT_TX_ERR:    rd_mux = 32'(cnt_shadow[3]);
      default:         rd_mux = '0;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      setting           <= RST_SETTING;
      idle_wait_len     <= RST_IDLE_WAIT;
      tx_permit_len     <= RST_TX_PERMIT;
      max_idle_len      <= RST_MAX_IDLE;
      tx_pre_len        <= RST_TX_PRE;
      filter            <= RST_FILTER;
      fm                <= '1;
      div_ls            <= DIV_LS;
      div_hs            <= DIV_HS;
      int_mask          <= '0;
      sticky            <= '0;
      irq               <= 1'b0;
      has_break         <= 1'b0;
      rx_ram_rd_done    <= 1'b0;
      rx_clean_all      <= 1'b0;
      tx_ram_switch     <= 1'b0;
      tx_abort          <= 1'b0;
      csr_readdata      <= '0;
      csr_readdatavalid <= 1'b0;
    end else begin
      if (we(A_SETTING))       setting       <= (setting & ~wm[6:0]) | (csr_writedata[6:0] & wm[6:0]);
      if (we(A_IDLE_WAIT_LEN)) idle_wait_len <= (idle_wait_len & ~wm[7:0]) | ctl;
      if (we(A_TX_PERMIT_LEN)) tx_permit_len <= (tx_permit_len & ~wm[9:0]) | (csr_writedata[9:0] & wm[9:0]);
      if (we(A_MAX_IDLE_LEN))  max_idle_len  <= (max_idle_len & ~wm[9:0]) | (csr_writedata[9:0] & wm[9:0]);
      if (we(A_TX_PRE_LEN))    tx_pre_len    <= (tx_pre_len & ~wm[1:0]) | ctl[1:0];
      if (we(A_FILTER))        filter        <= (filter & ~wm[7:0]) | ctl;
      if (we(A_DIV_LS))        div_ls        <= (div_ls & ~wm[15:0]) | (csr_writedata[15:0] & wm[15:0]);
      if (we(A_DIV_HS))        div_hs        <= (div_hs & ~wm[15:0]) | (csr_writedata[15:0] & wm[15:0]);
      if (we(A_INT_MASK))      int_mask      <= (int_mask & ~wm[7:0]) | ctl;
      if (we(A_FILTER_M0))     fm[31:0]      <= (fm[31:0] & ~wm) | (csr_writedata & wm);
      if (we(A_FILTER_M1))     fm[63:32]     <= (fm[63:32] & ~wm) | (csr_writedata & wm);
      // OR-ing the new events after the W1C mask lets a coincident event win over the clear.
      sticky            <= (sticky & ~(we(A_INT_FLAG) ? ctl : 8'h00)) | int_set;
      irq               <= |(int_flag & int_mask);
      rx_ram_rd_done    <= we(A_RX_CTRL) & ctl[1];
      rx_clean_all      <= we(A_RX_CTRL) & ctl[4];
      tx_ram_switch     <= we(A_TX_CTRL) & ctl[1];
      tx_abort          <= we(A_TX_CTRL) & ctl[4];
      has_break         <= (we(A_TX_CTRL) & ctl[5]) | (has_break & ~ack_break);
      csr_readdatavalid <= csr_read;
      if (csr_read) csr_readdata <= rd_mux;
    end
  for (genvar i = 0; i < 4; i++) begin : g_cnt
    cd_sat_cnt #(.CNT_W(CNT_W)) u_cnt (
      .clk(clk),
      .reset_n(reset_n),
      .inc(cnt_inc[i]),
      .clr(cnt_clr),
      .snap(cnt_snap),
      .live(cnt_live[i]),
      .shadow(cnt_shadow[i])
    );
  end
endmodule

// File: tb/tb_cd_csr_gen2.sv
// tb_cd_csr_gen2: scoreboard bench for cd_csr_gen2 with a per-cycle register-map model.
module tb_cd_csr_gen2;
  localparam int NF = 2;
  localparam int CW = 8;
  localparam int CMAX = (1 << CW) - 1;
  logic clk = 0, reset_n = 0;
  always #5 clk = ~clk;
  logic irq, csr_readdatavalid, csr_read = 0, csr_write = 0;
  logic [4:0] csr_address = 0;
  logic [3:0] csr_byteenable = 0;
  logic [31:0] csr_readdata, csr_writedata = 0;
  logic full_duplex, break_sync, arbitration, not_drop, user_crc, tx_invert, tx_push_pull;
  logic [7:0] idle_wait_len, filter;
  logic [9:0] tx_permit_len, max_idle_len;
  logic [1:0] tx_pre_len;
  logic [8*NF-1:0] filter_m;
  logic [15:0] div_ls, div_hs;
  logic rx_ram_rd_done, rx_clean_all, tx_ram_switch, tx_abort, has_break;
  logic [7:0] rx_ram_rd_flags = 0;
  logic rx_error = 0, rx_ram_lost = 0, rx_break = 0, rx_frame_done = 0;
  logic rx_pending = 0, bus_idle = 0, ack_break = 0, cd = 0, tx_err = 0, tx_pending = 0;

  cd_csr_gen2 #(.VERSION(8'h10), .DIV_LS(16'd346), .DIV_HS(16'd346), .N_FILTER(NF), .CNT_W(CW)) dut (
    .clk(clk), .reset_n(reset_n), .irq(irq),
    .csr_address(csr_address), .csr_byteenable(csr_byteenable), .csr_read(csr_read),
    .csr_readdata(csr_readdata), .csr_readdatavalid(csr_readdatavalid),
    .csr_write(csr_write), .csr_writedata(csr_writedata),
    .full_duplex(full_duplex), .break_sync(break_sync), .arbitration(arbitration),
    .not_drop(not_drop), .user_crc(user_crc), .tx_invert(tx_invert), .tx_push_pull(tx_push_pull),
    .idle_wait_len(idle_wait_len), .tx_permit_len(tx_permit_len), .max_idle_len(max_idle_len),
    .tx_pre_len(tx_pre_len), .filter(filter), .filter_m(filter_m), .div_ls(div_ls), .div_hs(div_hs),
    .rx_ram_rd_done(rx_ram_rd_done), .rx_clean_all(rx_clean_all), .rx_ram_rd_flags(rx_ram_rd_flags),
    .rx_error(rx_error), .rx_ram_lost(rx_ram_lost), .rx_break(rx_break), .rx_frame_done(rx_frame_done),
    .rx_pending(rx_pending), .bus_idle(bus_idle), .tx_ram_switch(tx_ram_switch), .tx_abort(tx_abort),
    .has_break(has_break), .ack_break(ack_break), .cd(cd), .tx_err(tx_err), .tx_pending(tx_pending)
  );

  int total = 0, bad = 0;
  logic [31:0] expq[$];
  logic [31:0] mon_e;
  logic [31:0] mdl[32];
  logic [31:0] wmask[32];
  logic [7:0] sf;
  bit hb;
  int cnt[4];
  int shd[4];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  always @(negedge clk)
    if (csr_readdatavalid) begin
      total++;
      if (expq.size() == 0) begin
        bad++;
        $display("FAIL rd_unexpected got=%h want=no_valid", csr_readdata);
      end else begin
        mon_e = expq.pop_front();
        if (csr_readdata !== mon_e) begin
          bad++;
          $display("FAIL rd_data got=%h want=%h", csr_readdata, mon_e);
        end
      end
    end

  task automatic init_model();
    logic [63:0] fmk;
    fmk = (64'd1 << (8 * NF)) - 64'd1;
    for (int i = 0; i < 32; i++) begin
      mdl[i] = 0;
      wmask[i] = 0;
    end
    mdl[0] = 32'h10;
    mdl[1] = 32'h10;  wmask[1] = 32'h7f;
    mdl[2] = 10;      wmask[2] = 32'hff;
    mdl[3] = 20;      wmask[3] = 32'h3ff;
    mdl[4] = 200;     wmask[4] = 32'h3ff;
    mdl[5] = 1;       wmask[5] = 32'h3;
    mdl[6] = 32'hff;  wmask[6] = 32'hff;
    mdl[7] = 346;     wmask[7] = 32'hffff;
    mdl[8] = 346;     wmask[8] = 32'hffff;
    wmask[10] = 32'hff;
    mdl[14] = fmk[31:0];  wmask[14] = fmk[31:0];
    mdl[15] = fmk[63:32]; wmask[15] = fmk[63:32];
    sf = 0;
    hb = 0;
    for (int i = 0; i < 4; i++) begin
      cnt[i] = 0;
      shd[i] = 0;
    end
  endtask

  function automatic logic [31:0] exp_rd(input logic [4:0] a);
    if (a >= 5'h10 && a <= 5'h13) return 32'(shd[a - 5'h10]);
    if (a == 5'h09) return {24'b0, sf | {2'b0, ~tx_pending, 3'b0, rx_pending, bus_idle}};
    if (a == 5'h0d) return {24'b0, rx_ram_rd_flags};
    if (a == 5'h0c) return hb ? 32'h20 : 32'h0;
    return mdl[a];
  endfunction

  // One bus cycle: drive, advance the model by one clock, then drop the bus and event pulses.
  task automatic cyc(input bit w, input bit r, input logic [4:0] a, input logic [31:0] d, input logic [3:0] be);
    logic [31:0] m;
    logic [3:0] ev;
    bit c0;
    csr_write = w; csr_read = r; csr_address = a; csr_writedata = d; csr_byteenable = be;
    if (r) expq.push_back(exp_rd(a));
    m = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}} & wmask[a];
    if (w) mdl[a] = (mdl[a] & ~m) | (d & m);
    if (w && a == 5'h09 && be[0]) sf = sf & ~d[7:0];
    sf = sf | {tx_err, cd, 1'b0, rx_error, rx_ram_lost, rx_break, 2'b0};
    if (ack_break) hb = 0;
    if (w && a == 5'h0c && be[0] && d[5]) hb = 1;
    if (w && a == 5'h14 && be[0] && d[1]) shd = cnt;
    c0 = w && a == 5'h14 && be[0] && d[0];
    ev = {tx_err, cd, rx_error | rx_ram_lost, rx_frame_done};
    for (int i = 0; i < 4; i++) cnt[i] = c0 ? 0 : (ev[i] && cnt[i] < CMAX) ? cnt[i] + 1 : cnt[i];
    @(posedge clk);
    #1;
    csr_write = 0; csr_read = 0;
    rx_error = 0; rx_ram_lost = 0; rx_break = 0; rx_frame_done = 0;
    ack_break = 0; cd = 0; tx_err = 0;
  endtask

  task automatic idle();
    cyc(0, 0, 5'h0, 0, 4'h0);
  endtask

  initial begin
    logic [4:0] a;
    init_model();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", 32'(csr_readdatavalid), 0);
    chk("rst_rdata", csr_readdata, 0);
    chk("rst_irq", 32'(irq), 0);
    chk("rst_arb", 32'({full_duplex, break_sync, arbitration, not_drop, user_crc, tx_invert, tx_push_pull}), 32'h10);
    chk("rst_filter", 32'({filter, filter_m}), 32'hffffff);
    chk("rst_div", {div_ls, div_hs}, {16'd346, 16'd346});
    chk("rst_strobes", 32'({rx_ram_rd_done, rx_clean_all, tx_ram_switch, tx_abort, has_break}), 0);
    reset_n = 1;
    @(posedge clk);
    #1;
    // register readback after reset, back to back
    cyc(0, 1, 5'h00, 0, 0);
    chk("rdv_high", 32'(csr_readdatavalid), 1);
    idle();
    chk("rdv_low", 32'(csr_readdatavalid), 0);
    foreach (mdl[i]) if (i != 11 && i != 20) cyc(0, 1, 5'(i), 0, 0);
    idle();
    // byte-lane gating on a 10-bit field
    cyc(1, 0, 5'h03, 32'h3ff, 4'b0010);
    chk("permit_hi", 32'(tx_permit_len), 32'h314);
    cyc(0, 1, 5'h03, 0, 0);
    cyc(1, 0, 5'h03, 32'h0ab, 4'b0001);
    chk("permit_lo", 32'(tx_permit_len), 32'h3ab);
    cyc(0, 1, 5'h03, 0, 0);
    // sticky flag, set-wins and irq lag
    rx_error = 1;
    idle();
    cyc(1, 0, 5'h0a, 32'h10, 4'h1);
    idle();
    idle();
    chk("irq_set", 32'(irq), 1);
    rx_error = 1;
    cyc(1, 0, 5'h09, 32'h10, 4'h1);
    cyc(0, 1, 5'h09, 0, 0);
    chk("irq_setwins", 32'(irq), 1);
    cyc(1, 0, 5'h09, 32'h10, 4'h1);
    chk("irq_lag", 32'(irq), 1);
    cyc(0, 1, 5'h09, 0, 0);
    chk("irq_clr", 32'(irq), 0);
    // saturation, clear+snapshot, event during clear
    for (int i = 0; i < 300; i++) begin
      rx_frame_done = 1;
      idle();
    end
    cyc(1, 0, 5'h14, 32'h2, 4'h1);
    cyc(0, 1, 5'h10, 0, 0);
    cyc(1, 0, 5'h14, 32'h3, 4'h1);
    cyc(0, 1, 5'h10, 0, 0);
    cyc(1, 0, 5'h14, 32'h2, 4'h1);
    cyc(0, 1, 5'h10, 0, 0);
    rx_frame_done = 1;
    rx_error = 1;
    rx_ram_lost = 1;
    idle();
    rx_frame_done = 1;
    cyc(1, 0, 5'h14, 32'h1, 4'h1);
    cyc(1, 0, 5'h14, 32'h2, 4'h1);
    cyc(0, 1, 5'h10, 0, 0);
    cyc(0, 1, 5'h11, 0, 0);
    // has_break set-wins and one-cycle strobes
    ack_break = 1;
    cyc(1, 0, 5'h0c, 32'h20, 4'h1);
    chk("hb_setwins", 32'(has_break), 1);
    ack_break = 1;
    idle();
    chk("hb_ack", 32'(has_break), 0);
    cyc(1, 0, 5'h0c, 32'h12, 4'h1);
    chk("tx_strobe_on", 32'({tx_abort, tx_ram_switch}), 32'h3);
    idle();
    chk("tx_strobe_off", 32'({tx_abort, tx_ram_switch}), 0);
    cyc(1, 0, 5'h0b, 32'h12, 4'h1);
    chk("rx_strobe_on", 32'({rx_clean_all, rx_ram_rd_done}), 32'h3);
    idle();
    chk("rx_strobe_off", 32'({rx_clean_all, rx_ram_rd_done}), 0);
    cyc(1, 0, 5'h0b, 32'h12, 4'h0);
    chk("strobe_be_gate", 32'({rx_clean_all, rx_ram_rd_done}), 0);
    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      rx_pending = 1'($urandom);
      bus_idle = 1'($urandom);
      tx_pending = 1'($urandom);
      rx_ram_rd_flags = 8'($urandom);
      rx_error = $urandom_range(0, 5) == 0;
      rx_ram_lost = $urandom_range(0, 5) == 0;
      rx_break = $urandom_range(0, 5) == 0;
      rx_frame_done = $urandom_range(0, 2) == 0;
      cd = $urandom_range(0, 3) == 0;
      tx_err = $urandom_range(0, 5) == 0;
      ack_break = $urandom_range(0, 5) == 0;
      case ($urandom_range(0, 2))
        0: cyc(1, 0, 5'($urandom), $urandom, 4'($urandom));
        1: begin
          a = 5'($urandom);
          while (a == 5'h0b || a == 5'h14) a = 5'($urandom);
          cyc(0, 1, a, 0, 0);
        end
        default: cyc(1, 0, 5'h14, 32'($urandom_range(0, 3)), 4'h1);
      endcase
    end
    idle();
    // asynchronous reset with a read in flight and live state nonzero
    bus_idle = 1;
    cyc(1, 0, 5'h0a, 32'hff, 4'h1);
    cyc(1, 0, 5'h06, 32'h12, 4'h1);
    cyc(1, 0, 5'h0e, 32'h1234, 4'hf);
    cyc(1, 0, 5'h0c, 32'h20, 4'h1);
    cd = 1;
    idle();
    cd = 1;
    idle();
    cyc(1, 0, 5'h14, 32'h2, 4'h1);
    cyc(0, 1, 5'h12, 0, 0);
    chk("pre_rst_irq", 32'(irq), 1);
    cyc(0, 1, 5'h10, 0, 0);
    reset_n = 0;
    #1;
    chk("rst_drop_valid", 32'(csr_readdatavalid), 0);
    expq.delete();
    init_model();
    chk("rst_mid_filter", 32'({filter, filter_m}), 32'hffffff);
    chk("rst_mid_state", 32'({irq, has_break}), 0);
    @(posedge clk);
    #1;
    reset_n = 1;
    cyc(1, 0, 5'h14, 32'h2, 4'h1);
    for (int i = 16; i < 20; i++) cyc(0, 1, 5'(i), 0, 0);
    cyc(0, 1, 5'h0e, 0, 0);
    idle();
    idle();
    chk("rd_drain", expq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
